pwm_value_filter: RTL and testbench

//  Sits directly downstream of pwm_decode, one instance per motor channel. Consumes each

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_avg_window.sv | 57 +++++
 rtl/pwm_value_filter.sv | 116 +++++++++++
 tb/tb_pwm_value_filter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM decode/filter channel.
package pwm_pkg;

  localparam int PWM_VALUE_W = 32;

  typedef enum logic [1:0] {
    PWMF_IDLE    = 2'd0,
    PWMF_ACQUIRE = 2'd1,
    PWMF_TRACK   = 2'd2,
    PWMF_LOST    = 2'd3
  } pwmf_state_t;

  function automatic logic pwm_in_range(input logic [PWM_VALUE_W-1:0] value,
                                        input logic [PWM_VALUE_W-1:0] lo,
                                        input logic [PWM_VALUE_W-1:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/pwm_avg_window.sv
// N-entry ring buffer with a running sum; sum_next is the window total once the
// current push commits, full says whether the window holds N samples after it.
module pwm_avg_window #(
  parameter int VALUE_W  = 32,
  parameter int AVG_LOG2 = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        flush,
  input  logic [VALUE_W-1:0]          value,
  output logic [VALUE_W+AVG_LOG2-1:0] sum_next,
  output logic                        full
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = VALUE_W + AVG_LOG2;
  localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FILL_W = AVG_LOG2 + 1;

  logic [VALUE_W-1:0] ram [N];
  logic [PTR_W-1:0]   wr_ptr;
  logic [FILL_W-1:0]  fill, fill_next;
  logic [SUM_W-1:0]   sum;
  logic [VALUE_W-1:0] oldest;
  logic               full_q;

  // A flush restarts the window with the incoming sample as its only member,
  // so neither the old sum nor the slot being overwritten contributes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    full_q    = (fill == FILL_W'(N));
    oldest    = (full_q && !flush) ? ram[wr_ptr] : '0;
    sum_next  = (flush ? '0 : sum) + SUM_W'(value) - SUM_W'(oldest);
    fill_next = flush ? FILL_W'(1) : (full_q ? fill : fill + 1'b1);
    full      = push ? (fill_next == FILL_W'(N)) : full_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      wr_ptr <= '0;
      fill   <= '0;
      sum    <= '0;
    end else if (push) begin
      wr_ptr <= (wr_ptr == PTR_W'(N - 1)) ? '0 : wr_ptr + 1'b1;
      fill   <= fill_next;
      sum    <= sum_next;
    end
  end

  // NOTE: the sample store has no reset; fill gates every read until a slot is written.
  always_ff @(posedge clk) begin
    if (push) ram[wr_ptr] <= value;
  end

endmodule

// File: rtl/pwm_value_filter.sv
// Range-checks, averages and loss-detects decoded PWM widths for one channel.
// Define PWM_FILTER_STATS_EN to add saturating reject / LOST-entry counters.
module pwm_value_filter
  import pwm_pkg::*;
#(
  parameter int                   VALUE_W        = PWM_VALUE_W,
  parameter int                   AVG_LOG2       = 2,
  parameter int unsigned          MIN_VALUE      = 1000,
  parameter int unsigned          MAX_VALUE      = 2000,
  parameter int unsigned          TIMEOUT_CYCLES = 100000,
  parameter int unsigned          REJECT_LIMIT   = 3,
  parameter logic [VALUE_W-1:0]   SAFE_VALUE     = '0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pwm_ready,
  input  logic [VALUE_W-1:0] i_pwm_value,
  output logic               o_valid,
  output logic [VALUE_W-1:0] o_value,
  output logic               o_range_err,
  output logic               o_lost,
  output logic [1:0]         o_state
`ifdef PWM_FILTER_STATS_EN
  ,
  output logic [15:0]        o_reject_cnt,
  output logic [15:0]        o_lost_cnt
`endif
);

  localparam int SUM_W = VALUE_W + AVG_LOG2;
  localparam int TW    = $clog2(TIMEOUT_CYCLES);
  localparam int RW    = $clog2(REJECT_LIMIT + 1);

  pwmf_state_t        state;
  logic [TW-1:0]      tmo_ctr;
  logic [RW-1:0]      rej_ctr;
  logic               accept, reject, tmo_term, rej_term, enter_lost, win_full;
  logic [SUM_W-1:0]   sum_next;
  logic [VALUE_W-1:0] avg;

  always_comb begin
    accept     = i_pwm_ready &&  pwm_in_range(PWM_VALUE_W'(i_pwm_value), MIN_VALUE, MAX_VALUE);
    reject     = i_pwm_ready && !accept;
    tmo_term   = (tmo_ctr == TW'(TIMEOUT_CYCLES - 1));
    rej_term   = reject && (rej_ctr == RW'(REJECT_LIMIT - 1));
    // An accepted sample always beats a timeout landing on the same edge.
    enter_lost = !accept && (state != PWMF_LOST) &&
                 (tmo_term || (rej_term && (state inside {PWMF_ACQUIRE, PWMF_TRACK})));
    avg        = sum_next[SUM_W-1:AVG_LOG2];
  end

  pwm_avg_window #(
    .VALUE_W (VALUE_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_window (
    .clk     (i_clk),
    .reset   (i_reset),
    .push    (accept),
    .flush   (accept && (state == PWMF_LOST)),
    .value   (i_pwm_value),
    .sum_next(sum_next),
    .full    (win_full)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= PWMF_IDLE;
      o_valid     <= 1'b0;
      o_value     <= SAFE_VALUE;
      o_range_err <= 1'b0;
      o_lost      <= 1'b0;
      tmo_ctr     <= '0;
      rej_ctr     <= '0;
    end else begin
      o_valid     <= 1'b0;
      o_range_err <= reject;

      if (accept)         tmo_ctr <= '0;
      else if (!tmo_term) tmo_ctr <= tmo_ctr + 1'b1;

      if (accept) rej_ctr <= '0;
      else if (reject && rej_ctr != RW'(REJECT_LIMIT)) rej_ctr <= rej_ctr + 1'b1;

      if (accept) begin
        o_lost <= 1'b0;
        if (win_full) begin
          state   <= PWMF_TRACK;
          o_valid <= 1'b1;
          o_value <= avg;
        end else begin
          state   <= PWMF_ACQUIRE;
          o_value <= SAFE_VALUE;
        end
      end else if (enter_lost) begin
        state   <= PWMF_LOST;
        o_lost  <= 1'b1;
        o_value <= SAFE_VALUE;
      end
    end
  end

  assign o_state = state;

`ifdef PWM_FILTER_STATS_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_reject_cnt <= '0;
      o_lost_cnt   <= '0;
    end else begin
      if (reject && o_reject_cnt != 16'hFFFF)   o_reject_cnt <= o_reject_cnt + 1'b1;
      if (enter_lost && o_lost_cnt != 16'hFFFF) o_lost_cnt   <= o_lost_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_value_filter.sv
// Directed bench for pwm_value_filter with a 50-cycle timeout.
module tb_pwm_value_filter;
  import pwm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pwm_ready = 1'b0;
  logic [31:0] pwm_value = '0;
  logic        valid, range_err, lost;
  logic [31:0] value;
  logic [1:0]  state;
`ifdef PWM_FILTER_STATS_EN
  logic [15:0] reject_cnt, lost_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pwm_value_filter #(.TIMEOUT_CYCLES(50)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_pwm_ready(pwm_ready),
    .i_pwm_value(pwm_value),
    .o_valid    (valid),
    .o_value    (value),
    .o_range_err(range_err),
    .o_lost     (lost),
    .o_state    (state)
`ifdef PWM_FILTER_STATS_EN
    ,
    .o_reject_cnt(reject_cnt),
    .o_lost_cnt  (lost_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Presents one sample for one clock; returns on the negedge after it was taken.
  task automatic send(input logic [31:0] v);
    @(negedge clk);
    pwm_ready = 1'b1;
    pwm_value = v;
    @(negedge clk);
    pwm_ready = 1'b0;
  endtask

  logic [31:0] t2_in  [4] = '{1000, 2000, 1000, 2000};
  logic [31:0] t2_exp [4] = '{1375, 1500, 1375, 1500};

  initial begin
    #1;
    check("rst_state", 32'(state), 32'(PWMF_IDLE));
    check("rst_valid", 32'(valid), 0);
    check("rst_value", value, 0);
    check("rst_lost",  32'(lost), 0);
    check("rst_rerr",  32'(range_err), 0);
    @(negedge clk);
    reset = 1'b0;

    // 1: fill the window with 1500
    for (int i = 0; i < 3; i++) begin
      send(1500);
      check("t1_acq_state", 32'(state), 32'(PWMF_ACQUIRE));
      check("t1_acq_valid", 32'(valid), 0);
    end
    send(1500);
    check("t1_track_state", 32'(state), 32'(PWMF_TRACK));
    check("t1_track_valid", 32'(valid), 1);
    check("t1_track_value", value, 1500);
    @(negedge clk);
    check("t1_valid_single", 32'(valid), 0);

    // 2: alternating extremes
    for (int i = 0; i < 4; i++) begin
      send(t2_in[i]);
      check("t2_valid", 32'(valid), 1);
      check("t2_value", value, t2_exp[i]);
    end

    // 3: rejects leave the window alone
    send(999);
    check("t3_rerr_lo", 32'(range_err), 1);
    check("t3_state_lo", 32'(state), 32'(PWMF_TRACK));
    check("t3_valid_lo", 32'(valid), 0);
    send(2001);
    check("t3_rerr_hi", 32'(range_err), 1);
    check("t3_state_hi", 32'(state), 32'(PWMF_TRACK));
    send(1500);
    check("t3_rerr_ok", 32'(range_err), 0);
    check("t3_valid_ok", 32'(valid), 1);
    check("t3_value_ok", value, 1625);

    // 4: reject limit drives LOST, recovery flushes the window
    send(2500);
    send(2500);
    check("t4_pre_lost", 32'(lost), 0);
    send(2500);
    check("t4_lost", 32'(lost), 1);
    check("t4_lost_state", 32'(state), 32'(PWMF_LOST));
    check("t4_lost_value", value, 0);
    for (int i = 0; i < 3; i++) begin
      send(1200);
      check("t4_acq_state", 32'(state), 32'(PWMF_ACQUIRE));
      check("t4_acq_lost", 32'(lost), 0);
    end
    send(1200);
    check("t4_track_state", 32'(state), 32'(PWMF_TRACK));
    check("t4_track_value", value, 1200);

    // 5: timeout terminal count, then accept on the terminal cycle
    repeat (49) @(negedge clk);
    check("t5_before_tmo", 32'(state), 32'(PWMF_TRACK));
    @(negedge clk);
    check("t5_tmo_state", 32'(state), 32'(PWMF_LOST));
    check("t5_tmo_lost", 32'(lost), 1);
    check("t5_tmo_value", value, 0);
    repeat (4) send(1800);
    check("t5_retrack", 32'(state), 32'(PWMF_TRACK));
    check("t5_retrack_value", value, 1800);
    repeat (48) @(negedge clk);
    send(1900);
    check("t5_term_state", 32'(state), 32'(PWMF_TRACK));
    check("t5_term_valid", 32'(valid), 1);
    check("t5_term_value", value, 1825);
    check("t5_term_lost", 32'(lost), 0);

    // 6: async reset mid-ACQUIRE
    repeat (3) send(2500);
    check("t6_lost", 32'(state), 32'(PWMF_LOST));
    send(1000);
    send(1000);
    send(500);
    check("t6_acq_state", 32'(state), 32'(PWMF_ACQUIRE));
    check("t6_acq_rerr", 32'(range_err), 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_state", 32'(state), 32'(PWMF_IDLE));
    check("t6_rst_rerr", 32'(range_err), 0);
    check("t6_rst_value", value, 0);
    check("t6_rst_valid", 32'(valid), 0);
    check("t6_rst_lost", 32'(lost), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1600);
      check("t6_refill_state", 32'(state), 32'(PWMF_ACQUIRE));
      check("t6_refill_valid", 32'(valid), 0);
    end
    send(1600);
    check("t6_track_state", 32'(state), 32'(PWMF_TRACK));
    check("t6_track_value", value, 1600);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
